// File: rtl/deserializer_pkg.sv
// deserializer_pkg: shared constants and output-state encoding for the 32-bit deserializer
package deserializer_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int CNT_W = 5;
  typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/sipo_shift_register_32_bit.sv
// sipo_shift_register_32_bit: MSB-first shift register and bit counter with word-completion strobe
module sipo_shift_register_32_bit
  import deserializer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic                  din,
  output logic [CNT_W-1:0]      cnt,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] word
);
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  always_comb begin
    word    = {shift_q[DATA_WIDTH-2:0], din};
    shift_d = capture ? word : shift_q;
    cnt_d   = capture ? cnt_q + CNT_W'(1) : cnt_q;
    done    = capture && (cnt_q == CNT_W'(DATA_WIDTH - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/serial_to_parallel_deserializer_32_bit.sv
// serial_to_parallel_deserializer_32_bit: serial-in word builder with a one-entry valid/ready output and sticky overflow
module serial_to_parallel_deserializer_32_bit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Shift_Data_Signal_In,
  input  logic                  Serial_Data_In,
  input  logic                  Data_Ready_In,
  output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
  output logic                  Data_Valid_Out,
  output logic                  Overflow_Out,
  output logic [4:0]            Bit_Count_Out
);
  import deserializer_pkg::*;
  logic                  done;
  logic [DATA_WIDTH-1:0] word;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;
  sipo_shift_register_32_bit u_sipo (
    .clk     (Clk_In),
    .rst     (Reset_In),
    .capture (Enable_In && Shift_Data_Signal_In),
    .din     (Serial_Data_In),
    .cnt     (Bit_Count_Out),
    .done    (done),
    .word    (word)
  );
  // A completion while full and not drained is dropped; the held word wins.
  always_comb begin
    state_d = (done || (state_q == FULL && !Data_Ready_In)) ? FULL : EMPTY;
    data_d  = (done && (state_q == EMPTY || Data_Ready_In)) ? word : data_q;
    ovf_d   = ovf_q || (done && state_q == FULL && !Data_Ready_In);
  end
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end
  assign Parallel_Data_Out = data_q;
  assign Data_Valid_Out    = (state_q == FULL);
  assign Overflow_Out      = ovf_q;
endmodule

// File: tb/tb_serial_to_parallel_deserializer_32_bit.sv
// tb_serial_to_parallel_deserializer_32_bit: scoreboard bench with a queue-based reference model
module tb_serial_to_parallel_deserializer_32_bit;
  logic        clk = 0;
  logic        rst = 0, en = 0, sh = 0, din = 0, rdy = 0;
  logic [31:0] pdo;
  logic        vld, ovf;
  logic [4:0]  cnt;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] d; logic v; logic o; logic [4:0] c;} exp_t;
  exp_t exp_q[$];
  bit   m_bits[$];
  logic [31:0] m_data = 0;
  logic m_valid = 0, m_ovf = 0;
  serial_to_parallel_deserializer_32_bit #(.DATA_WIDTH(32)) dut (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Shift_Data_Signal_In(sh),
    .Serial_Data_In(din), .Data_Ready_In(rdy), .Parallel_Data_Out(pdo),
    .Data_Valid_Out(vld), .Overflow_Out(ovf), .Bit_Count_Out(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // Reference: collect captured bits in a list; 32 of them make a word.
  task automatic step(bit r, bit e, bit s, bit d, bit y);
    logic [31:0] w;
    bit comp;
    exp_t x;
    @(negedge clk);
    rst = r; en = e; sh = s; din = d; rdy = y;
    comp = 0;
    w = 0;
    if (r) begin
      m_bits.delete();
      m_data = 0; m_valid = 0; m_ovf = 0;
    end else begin
      if (e && s) begin
        m_bits.push_back(d);
        if (m_bits.size() == 32) begin
          foreach (m_bits[i]) w = (w << 1) | 32'(m_bits[i]);
          m_bits.delete();
          comp = 1;
        end
      end
      if (comp) begin
        if (!m_valid || y) begin
          m_data = w;
          m_valid = 1;
        end else m_ovf = 1;
      end else if (m_valid && y) m_valid = 0;
    end
    x.d = m_data; x.v = m_valid; x.o = m_ovf; x.c = 5'(m_bits.size());
    exp_q.push_back(x);
  endtask
  task automatic send_bits(logic [31:0] w, int n, bit y);
    for (int i = 0; i < n; i++) step(0, 1, 1, w[n-1-i], y);
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("mon_data", pdo, x.d);
        chk("mon_valid", 32'(vld), 32'(x.v));
        chk("mon_ovf", 32'(ovf), 32'(x.o));
        chk("mon_cnt", 32'(cnt), 32'(x.c));
      end
    end
  end
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    settle();
    chk("rst_valid", 32'(vld), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_data", pdo, 0);
    chk("rst_ovf", 32'(ovf), 0);
    send_bits(32'hA5A5F00F, 32, 1);
    settle();
    chk("a5_valid", 32'(vld), 1);
    chk("a5_data", pdo, 32'hA5A5F00F);
    step(0, 0, 0, 0, 1);
    settle();
    chk("a5_drain", 32'(vld), 0);
    chk("a5_ovf", 32'(ovf), 0);
    send_bits(32'hFFFF, 16, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, i[0], 1);
      settle();
      chk("gap_cnt", 32'(cnt), 16);
    end
    send_bits(32'h0, 16, 1);
    settle();
    chk("gap_word", pdo, 32'hFFFF0000);
    step(1, 0, 0, 0, 0);
    send_bits(32'h12345678, 32, 0);
    settle();
    chk("ov_first_ovf", 32'(ovf), 0);
    send_bits(32'hDEADBEEF, 32, 0);
    settle();
    chk("ov_data", pdo, 32'h12345678);
    chk("ov_valid", 32'(vld), 1);
    chk("ov_ovf", 32'(ovf), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    settle();
    chk("ov_sticky", 32'(ovf), 1);
    step(1, 0, 0, 0, 0);
    send_bits(32'h00000001, 32, 0);
    send_bits(32'h40000000, 31, 0);
    step(0, 1, 1, 0, 1);
    settle();
    chk("b2b_valid", 32'(vld), 1);
    chk("b2b_data", pdo, 32'h80000000);
    chk("b2b_ovf", 32'(ovf), 0);
    send_bits(32'hFFFFF, 20, 1);
    step(1, 1, 1, 1, 1);
    settle();
    chk("rst_mid_cnt", 32'(cnt), 0);
    send_bits(32'hCAFEBABE, 32, 0);
    settle();
    chk("cafe_data", pdo, 32'hCAFEBABE);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
    settle();
    settle();
    chk("drain", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
